// File: rtl/spi_cmd_frontend_if.sv
// SPI command front-end bus bundle.
// Pad side: sck, cs_n, mosi in; miso out.
// Decoded side: rising/falling strobes, si, reset_flag, sel, cmd, cmd_valid out;
// so_in carries the serial outputs of the NT downstream targets back in.
// The slave modport is the front-end's view; the master modport is the driver's view.
interface spi_cmd_frontend_if #(
  parameter int unsigned NT = 4
);
  logic          sck;
  logic          cs_n;
  logic          mosi;
  logic          miso;
  logic          rising;
  logic          falling;
  logic          si;
  logic          reset_flag;
  logic [NT-1:0] sel;
  logic [NT-1:0] so_in;
  logic [7:0]    cmd;
  logic          cmd_valid;

  modport slave (
    input  sck, cs_n, mosi, so_in,
    output miso, rising, falling, si, reset_flag, sel, cmd, cmd_valid
  );

  modport master (
    output sck, cs_n, mosi, so_in,
    input  miso, rising, falling, si, reset_flag, sel, cmd, cmd_valid
  );
endinterface

// File: rtl/spi_cmd_frontend.sv
// SPI (mode 0) command front-end.
// Synchronizes the asynchronous SPI pads into the clk domain, produces one-clk
// sck edge strobes with aligned data, captures the first byte of each
// transaction as a command and routes the transaction to the target whose
// index is in cmd[3:0]. miso is a combinational mux of the selected target.
// Ports:
//   clk   - system clock, all state on posedge
//   reset - synchronous active-high reset
//   bus   - spi_cmd_frontend_if slave modport (pads, strobes, select, command)
module spi_cmd_frontend #(
  parameter int unsigned NT   = 4,
  parameter int unsigned SYNC = 2
) (
  input logic                clk,
  input logic                reset,
  spi_cmd_frontend_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  // Cycles until the sync chain plus history flop reflect real pad values.
  localparam int unsigned FlushLen = SYNC + 1;
  localparam int unsigned FlushW   = $clog2(FlushLen + 1);

  logic [SYNC-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic            sck_hist_q, cs_hist_q;
  logic            sck_s, cs_s, mosi_s;
  logic            cs_fall, cs_rise;

  logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;
  logic              flushed;
  logic              armed_q, armed_d;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [6:0]    shift_q, shift_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    cmd_byte;
  logic [NT-1:0] sel_q, sel_d;
  logic          rising_q, rising_d;
  logic          falling_q, falling_d;
  logic          si_q;
  logic          reset_flag_q, reset_flag_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          miso;

  // Pad synchronizers; reset values match an idle bus so no edge is seen on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_hist_q  <= 1'b0;
      cs_hist_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC-2:0], bus.sck};
      cs_sync_q   <= {cs_sync_q[SYNC-2:0], bus.cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC-2:0], bus.mosi};
      sck_hist_q  <= sck_sync_q[SYNC-1];
      cs_hist_q   <= cs_sync_q[SYNC-1];
    end
  end

  assign sck_s   = sck_sync_q[SYNC-1];
  assign cs_s    = cs_sync_q[SYNC-1];
  assign mosi_s  = mosi_sync_q[SYNC-1];
  assign cs_fall = cs_hist_q & ~cs_s;
  assign cs_rise = ~cs_hist_q & cs_s;

  // A transaction may only start after cs_n has been seen high from the real
  // pad; this blocks a start when reset releases with cs_n already low.
  assign flushed = (flush_cnt_q == FlushW'(FlushLen));

  always_comb begin
    flush_cnt_d = flushed ? flush_cnt_q : flush_cnt_q + FlushW'(1);
    armed_d     = armed_q | (flushed & cs_hist_q);
  end

  // Strobes: cs_n high suppresses them, and a cs_n fall in the same cycle wins.
  always_comb begin
    rising_d  = sck_s & ~sck_hist_q & ~cs_s & ~cs_fall;
    falling_d = ~sck_s & sck_hist_q & ~cs_s & ~cs_fall;
  end

  assign cmd_byte = {shift_q, si_q};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    cmd_d        = cmd_q;
    sel_d        = sel_q;
    reset_flag_d = 1'b0;
    cmd_valid_d  = 1'b0;
    if (cs_rise) begin
      state_d = StIdle;
      sel_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall && armed_q) begin
            reset_flag_d = 1'b1;
            cnt_d        = '0;
            shift_d      = '0;
            state_d      = StCmd;
          end
        end
        StCmd: begin
          if (rising_q) begin
            shift_d = cmd_byte[6:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              cmd_d       = cmd_byte;
              cmd_valid_d = 1'b1;
              state_d     = StData;
              // Out-of-range indices match no bit, leaving sel all-zero.
              for (int unsigned k = 0; k < NT; k++) begin
                sel_d[k] = (cmd_byte[3:0] == 4'(k));
              end
            end
          end
        end
        StData: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt_q  <= '0;
      armed_q      <= 1'b0;
      state_q      <= StIdle;
      cnt_q        <= '0;
      shift_q      <= '0;
      cmd_q        <= 8'h00;
      sel_q        <= '0;
      rising_q     <= 1'b0;
      falling_q    <= 1'b0;
      si_q         <= 1'b0;
      reset_flag_q <= 1'b0;
      cmd_valid_q  <= 1'b0;
    end else begin
      flush_cnt_q  <= flush_cnt_d;
      armed_q      <= armed_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      cmd_q        <= cmd_d;
      sel_q        <= sel_d;
      rising_q     <= rising_d;
      falling_q    <= falling_d;
      si_q         <= mosi_s;
      reset_flag_q <= reset_flag_d;
      cmd_valid_q  <= cmd_valid_d;
    end
  end

  always_comb begin
    miso = (state_q == StData) & |(sel_q & bus.so_in);
  end

  assign bus.miso       = miso;
  assign bus.rising     = rising_q;
  assign bus.falling    = falling_q;
  assign bus.si         = si_q;
  assign bus.reset_flag = reset_flag_q;
  assign bus.sel        = sel_q;
  assign bus.cmd        = cmd_q;
  assign bus.cmd_valid  = cmd_valid_q;

endmodule

// File: tb/tb_spi_cmd_frontend.sv
// Bench for spi_cmd_frontend: directed SPI transactions; expected command/select
// pairs and transmitted bits are queued as stimulus is issued and a monitor pops
// and compares them whenever the DUT raises cmd_valid or a rising strobe.
module tb_spi_cmd_frontend;
  localparam int unsigned NT   = 4;
  localparam int unsigned SYNC = 2;

  logic clk;
  logic reset;

  spi_cmd_frontend_if #(.NT(NT)) bus ();

  spi_cmd_frontend #(.NT(NT), .SYNC(SYNC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int rflag_cnt = 0;
  int cmdv_cnt = 0;
  bit watch_miso0 = 1'b0;

  logic [11:0] exp_cmd_q[$];  // {cmd, sel}
  logic        exp_bit_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  task automatic clear_counts();
    rise_cnt  = 0;
    fall_cnt  = 0;
    rflag_cnt = 0;
    cmdv_cnt  = 0;
  endtask

  // Mode 0: data set while sck low, sampled on sck rising. ph in clk periods.
  task automatic send_bits(input logic [7:0] b, input int n, input int ph);
    for (int i = 7; i > 7 - n; i--) begin
      bus.mosi = b[i];
      exp_bit_q.push_back(b[i]);
      #(ph * 10);
      bus.sck = 1'b1;
      #(ph * 10);
      bus.sck = 1'b0;
    end
    #(ph * 10);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.reset_flag) rflag_cnt++;
      if (bus.falling) fall_cnt++;
      if (bus.rising) begin
        rise_cnt++;
        if (exp_bit_q.size() == 0) fail_now("si_unexpected_strobe");
        else check("si_bit", {31'd0, bus.si}, {31'd0, exp_bit_q.pop_front()});
      end
      if (bus.cmd_valid) begin
        cmdv_cnt++;
        if (exp_cmd_q.size() == 0) fail_now("cmd_valid_unexpected");
        else begin
          logic [11:0] e;
          e = exp_cmd_q.pop_front();
          check("cmd_on_valid", {24'd0, bus.cmd}, {24'd0, e[11:4]});
          check("sel_on_valid", {28'd0, bus.sel}, {28'd0, e[3:0]});
        end
      end
      if (watch_miso0) check("miso_zero", {31'd0, bus.miso}, 32'd0);
    end
  end

  logic [7:0] data_bytes [3];
  logic [3:0] so_vec [6];
  logic       miso_vec [6];
  int         clr_at;

  initial begin
    data_bytes = '{8'hA5, 8'h3C, 8'hFF};
    so_vec     = '{4'b0000, 4'b0010, 4'b0100, 4'b0110, 4'b1011, 4'b1111};
    miso_vec   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    bus.cs_n  = 1'b1;
    bus.sck   = 1'b0;
    bus.mosi  = 1'b0;
    bus.so_in = '0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sel", {28'd0, bus.sel}, 32'd0);
    check("rst_rising", {31'd0, bus.rising}, 32'd0);
    check("rst_falling", {31'd0, bus.falling}, 32'd0);
    check("rst_reset_flag", {31'd0, bus.reset_flag}, 32'd0);
    check("rst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
    check("rst_cmd", {24'd0, bus.cmd}, 32'h00);
    check("rst_si", {31'd0, bus.si}, 32'd0);
    check("rst_miso", {31'd0, bus.miso}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("no_false_start", rflag_cnt, 0);

    // Command 0x01 plus three data bytes.
    clear_counts();
    bus.cs_n = 1'b0;
    repeat (6) @(negedge clk);
    exp_cmd_q.push_back({8'h01, 4'b0010});
    send_bits(8'h01, 8, 6);
    check("t1_sel_after_cmd", {28'd0, bus.sel}, 32'b0010);
    bus.so_in = 4'b0010;
    #1 check("t1_miso_sel1", {31'd0, bus.miso}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      send_bits(data_bytes[i], 8, 6);
      check("t1_sel_data", {28'd0, bus.sel}, 32'b0010);
    end
    bus.so_in = '0;
    @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check("t1_reset_flags", rflag_cnt, 1);
    check("t1_cmd_valids", cmdv_cnt, 1);
    check("t1_cmd", {24'd0, bus.cmd}, 32'h01);
    check("t1_rising", rise_cnt, 32);
    check("t1_falling", fall_cnt, 32);
    check("t1_sel_cleared", {28'd0, bus.sel}, 32'd0);

    // Out-of-range target 7: nothing selected, miso held low.
    clear_counts();
    bus.so_in   = 4'b1111;
    watch_miso0 = 1'b1;
    bus.cs_n    = 1'b0;
    repeat (6) @(negedge clk);
    exp_cmd_q.push_back({8'h07, 4'b0000});
    send_bits(8'h07, 8, 6);
    check("t2_sel_zero", {28'd0, bus.sel}, 32'd0);
    send_bits(8'h96, 8, 6);
    @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (8) @(negedge clk);
    watch_miso0 = 1'b0;
    bus.so_in   = '0;
    check("t2_cmd_valids", cmdv_cnt, 1);
    check("t2_cmd", {24'd0, bus.cmd}, 32'h07);

    // Aborted command after 5 bits, then command 0x02.
    clear_counts();
    bus.cs_n = 1'b0;
    repeat (6) @(negedge clk);
    send_bits(8'hB3, 5, 6);
    @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check("t3_no_cmd_valid", cmdv_cnt, 0);
    check("t3_cmd_kept", {24'd0, bus.cmd}, 32'h07);
    bus.cs_n = 1'b0;
    repeat (6) @(negedge clk);
    exp_cmd_q.push_back({8'h02, 4'b0100});
    send_bits(8'h02, 8, 6);
    check("t3_reset_flags", rflag_cnt, 2);
    check("t3_sel", {28'd0, bus.sel}, 32'b0100);

    // miso follows so_in[2] only, then clears soon after cs_n rises.
    for (int i = 0; i < 6; i++) begin
      bus.so_in = so_vec[i];
      #1 check("t4_miso_follow", {31'd0, bus.miso}, {31'd0, miso_vec[i]});
    end
    @(negedge clk);
    bus.cs_n = 1'b1;
    clr_at = -1;
    for (int n = 1; n <= int'(SYNC) + 2; n++) begin
      @(negedge clk);
      if (clr_at < 0 && bus.sel == '0 && bus.miso == 1'b0) clr_at = n;
    end
    check("t4_release_in_time", {31'd0, clr_at > 0}, 32'd1);
    check("t4_miso_off", {31'd0, bus.miso}, 32'd0);
    check("t4_sel_off", {28'd0, bus.sel}, 32'd0);
    bus.so_in = '0;
    repeat (4) @(negedge clk);

    // Reset during DATA with cs_n held low.
    clear_counts();
    bus.cs_n = 1'b0;
    repeat (6) @(negedge clk);
    exp_cmd_q.push_back({8'h01, 4'b0010});
    send_bits(8'h01, 8, 6);
    check("t5_sel_before_rst", {28'd0, bus.sel}, 32'b0010);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("t5_sel_after_rst", {28'd0, bus.sel}, 32'd0);
    check("t5_cmd_after_rst", {24'd0, bus.cmd}, 32'h00);
    check("t5_no_flag_held_low", rflag_cnt, 1);
    bus.cs_n = 1'b1;
    repeat (6) @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (6) @(negedge clk);
    check("t5_flag_on_new_fall", rflag_cnt, 2);
    exp_cmd_q.push_back({8'h03, 4'b1000});
    send_bits(8'h03, 8, 6);
    check("t5_sel3", {28'd0, bus.sel}, 32'b1000);
    @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (8) @(negedge clk);

    // Minimum 4-clk sck phase with a clk-relative offset per byte.
    clear_counts();
    bus.cs_n = 1'b0;
    repeat (6) @(negedge clk);
    exp_cmd_q.push_back({8'h00, 4'b0001});
    #($urandom_range(1, 4));
    send_bits(8'h00, 8, 4);
    #($urandom_range(1, 4));
    send_bits(8'h5A, 8, 4);
    #($urandom_range(1, 4));
    send_bits(8'hC3, 8, 4);
    @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check("t6_rising", rise_cnt, 24);
    check("t6_falling", fall_cnt, 24);
    check("t6_cmd_valids", cmdv_cnt, 1);
    check("t6_cmd", {24'd0, bus.cmd}, 32'h00);

    check("cmd_queue_drained", exp_cmd_q.size(), 0);
    check("bit_queue_drained", exp_bit_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_frontend.md
SPI_CMD_FRONTEND -- requirements
Module: spi_cmd_frontend

Interface
REQ-001 Parameter NT, default 4: number of downstream SPI targets (1..16).
REQ-002 Parameter SYNC, default 2: synchronizer flops per pad input (>=2).
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sck  input  1  SPI clock pad, asynchronous to clk; mode 0.
REQ-006 cs_n  input  1  SPI chip select pad, active-low, asynchronous.
REQ-007 mosi  input  1  SPI data in pad, asynchronous.
REQ-008 miso  output  1  SPI data out to pad.
REQ-009 rising  output  1  one-clk strobe, synchronized sck rising edge.
REQ-010 falling  output  1  one-clk strobe, synchronized sck falling edge.
REQ-011 si  output  1  synchronized mosi, aligned with the strobes.
REQ-012 reset_flag  output  1  one-clk pulse at start of each transaction.
REQ-013 sel  output  NT  one-hot target select; bit k high while target k owns the transaction.
REQ-014 so_in  input  NT  serial outputs of the targets; bit k from target k.
REQ-015 cmd  output  8  last completed command byte.
REQ-016 cmd_valid  output  1  one-clk pulse when cmd is updated.

Function
REQ-017 sck, cs_n and mosi SHALL each pass through SYNC flops plus one history flop; all decisions use synchronized values only.
REQ-018 rising/falling SHALL be registered and high exactly one clk; with SYNC=2, high in the 3rd clk after the pad edge is sampled; si has identical delay.
REQ-019 rising/falling SHALL be suppressed while synchronized cs_n is high.
REQ-020 Operating constraint: each sck phase lasts >=4 clk periods; faster sck is out of scope.
REQ-021 FSM states: IDLE, CMD, DATA.
REQ-022 IDLE: on synchronized cs_n high->low, pulse reset_flag one clk, clear 3-bit bit counter and shift register, go CMD.
REQ-023 CMD: on each rising, shift si into the command shift register MSB first and increment the bit counter.
REQ-024 CMD: on the 8th rising, load cmd, pulse cmd_valid one clk later, go DATA.
REQ-025 On DATA entry, sel[cmd[3:0]] SHALL go high in the same cycle as cmd_valid when cmd[3:0] < NT; otherwise sel stays all-zero and the transaction is ignored.
REQ-026 DATA: sel SHALL stay constant until synchronized cs_n goes high; rising/falling/si keep forwarding.
REQ-027 Any state: synchronized cs_n low->high SHALL clear sel and the bit counter next cycle and return to IDLE; an incomplete command SHALL NOT pulse cmd_valid and SHALL NOT change cmd.
REQ-028 cs_n assertion and an sck edge detected in the same cycle: the cs_n event wins; that sck edge produces no strobe.
REQ-029 miso SHALL be so_in[k] for the selected k in DATA; 0 in IDLE, CMD, or with no target selected. This path is combinational.
REQ-030 cmd[7:4] is reserved; it is passed through on cmd and ignored for decoding.

Reset
REQ-031 While reset is high, on the next posedge: state IDLE; sel=0, rising=0, falling=0, reset_flag=0, cmd_valid=0, cmd=8'h00, si=0; miso=0.
REQ-032 The synchronizer and history flops SHALL reset to cs_n=1, sck=0, mosi=0; this prevents a false edge or transaction start after reset release.
REQ-033 Reset asserted mid-transaction SHALL abort the transaction; after release, a new cs_n falling edge is required before reset_flag fires.

Verification
REQ-034 Send cs_n low, then byte 8'h01 and 3 data bytes -> exactly 1 reset_flag pulse; cmd=8'h01; 1 cmd_valid pulse; sel=4'b0010 until cs_n high; 32 rising and 32 falling strobes total.
REQ-035 Send byte 8'h07 with NT=4 -> cmd_valid pulses with cmd=8'h07; sel stays 0; miso stays 0 throughout.
REQ-036 Raise cs_n after 5 command bits -> no cmd_valid; cmd keeps its previous value; state IDLE. Next transaction 8'h02 -> sel=4'b0100.
REQ-037 In DATA with target 2 selected, toggle so_in[2] and so_in[1] -> miso follows so_in[2] only; raise cs_n -> miso=0 and sel=0 within SYNC+2 clk.
REQ-038 Assert reset during DATA, then release with cs_n held low -> sel=0; no reset_flag until cs_n goes high and falls again.
REQ-039 Run sck at the minimum 4-clk phase with a random clk-relative phase -> every sck edge yields exactly one strobe; sampled bits match the transmitted bytes.
